rcc_clk_gate_ctrl: RTL and testbench

//  Demand-driven enable controller for one gated clock branch.

---
 rtl/rcc_clk_gate_ctrl.sv | 134 +++++++++++++
 tb/tb_rcc_clk_gate_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcc_clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rcc_clk_gate_ctrl
//  Purpose  : Demand-driven enable controller for one gated clock branch.
//             Merges per-requester req/ack handshakes into a single enable
//             for the downstream clock-gating cell.
//             - A wake-up delay runs before any ack is granted.
//             - An idle hysteresis period runs before the branch is gated.
//             - A minimum off time is enforced after gating.
//  Revision : 1.0 - initial release
// ============================================================================
module rcc_clk_gate_ctrl #(
  parameter int REQ_NUM        = 4,
  parameter int WAKE_CYCLES    = 2,
  parameter int IDLE_CYCLES    = 16,
  parameter int OFF_MIN_CYCLES = 4,
  parameter int CW             = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               testmode,
  input  logic               force_on,
  input  logic [REQ_NUM-1:0] req,
  output logic [REQ_NUM-1:0] ack,
  output logic               active,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_WAKE = 3'd1,
    S_ON   = 3'd2,
    S_HOLD = 3'd3,
    S_COOL = 3'd4
  } state_t;

  // Terminal counter values for each timed state.
  localparam logic [CW-1:0] C_WAKE_LAST = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] C_IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] C_OFF_LAST  = CW'(OFF_MIN_CYCLES - 1);
  localparam logic [CW-1:0] C_CNT_MAX   = {CW{1'b1}};

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [REQ_NUM-1:0] ack_q, ack_d;
  logic               active_q, active_d;
  logic               any_req;
  logic [CW-1:0]      cnt_inc;

  // Testmode counts as demand, so the enable stays up once testmode drops.
  assign any_req = (|req) | force_on | testmode;

  // Counter never wraps; it holds at all-ones if ever reached.
  assign cnt_inc = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // Next-state, counter and ack logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    case (state_q)
      S_OFF: begin
        if (any_req) begin
          state_d = S_WAKE;
          cnt_d   = '0;
        end
      end
      S_WAKE: begin
        // Request changes are ignored until the wake-up delay has elapsed.
        if (cnt_q == C_WAKE_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ON: begin
        ack_d = req;
        if (!any_req) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        ack_d = req;
        if (any_req) begin
          state_d = S_ON;
          cnt_d   = '0;
        end else if (cnt_q == C_IDLE_LAST) begin
          state_d = S_COOL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_COOL: begin
        // Requests stay pending here; OFF picks them up on the next edge.
        if (cnt_q == C_OFF_LAST) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
      end
    endcase
    // The enable is high in every state where the branch clock must run.
    active_d = (state_d == S_WAKE) || (state_d == S_ON) || (state_d == S_HOLD);
  end

  // State, counter, ack and enable registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      ack_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      active_q <= active_d;
    end
  end

  assign ack    = ack_q;
  assign active = active_q | testmode;
  assign state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rcc_clk_gate_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rcc_clk_gate_ctrl
//  Purpose  : Self-checking bench for rcc_clk_gate_ctrl: vector table,
//             directed multi-cycle sequences and randomized stimulus
//             compared against a countdown-timer reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rcc_clk_gate_ctrl;

  localparam int REQ_NUM        = 4;
  localparam int WAKE_CYCLES    = 2;
  localparam int IDLE_CYCLES    = 16;
  localparam int OFF_MIN_CYCLES = 4;
  localparam int CW             = 8;

  logic               clk      = 1'b0;
  logic               rst      = 1'b1;
  logic               testmode = 1'b0;
  logic               force_on = 1'b0;
  logic [REQ_NUM-1:0] req      = '0;
  logic [REQ_NUM-1:0] ack;
  logic               active;
  logic [2:0]         state;

  int checks = 0;
  int errors = 0;

  rcc_clk_gate_ctrl #(
    .REQ_NUM        (REQ_NUM),
    .WAKE_CYCLES    (WAKE_CYCLES),
    .IDLE_CYCLES    (IDLE_CYCLES),
    .OFF_MIN_CYCLES (OFF_MIN_CYCLES),
    .CW             (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .testmode (testmode),
    .force_on (force_on),
    .req      (req),
    .ack      (ack),
    .active   (active),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Reference model: the branch is either waking (countdown), running
  // (optionally idling), cooling (countdown) or off.
  int                 m_wake_left = 0;
  int                 m_cool_left = 0;
  int                 m_idle      = 0;
  bit                 m_running   = 1'b0;
  bit                 m_holding   = 1'b0;
  logic [REQ_NUM-1:0] m_ack       = '0;

  always @(posedge clk) begin : ref_model
    bit demand;
    demand = (|req) || force_on || testmode;
    if (rst) begin
      m_wake_left = 0; m_cool_left = 0; m_idle = 0;
      m_running = 1'b0; m_holding = 1'b0; m_ack = '0;
    end else if (m_wake_left > 0) begin
      m_ack = '0;
      m_wake_left--;
      if (m_wake_left == 0) begin
        m_running = 1'b1;
        m_holding = 1'b0;
      end
    end else if (m_cool_left > 0) begin
      m_ack = '0;
      m_cool_left--;
    end else if (m_running) begin
      m_ack = req;
      if (!m_holding) begin
        if (!demand) begin
          m_holding = 1'b1;
          m_idle = 0;
        end
      end else if (demand) begin
        m_holding = 1'b0;
      end else if (m_idle == IDLE_CYCLES - 1) begin
        m_running = 1'b0;
        m_holding = 1'b0;
        m_cool_left = OFF_MIN_CYCLES;
      end else begin
        m_idle++;
      end
    end else begin
      m_ack = '0;
      if (demand) m_wake_left = WAKE_CYCLES;
    end
  end

  function automatic logic [2:0] m_state();
    if (m_wake_left > 0) return 3'd1;
    if (m_cool_left > 0) return 3'd4;
    if (m_running) return m_holding ? 3'd3 : 3'd2;
    return 3'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic               rst;
    logic               tm;
    logic               fo;
    logic [REQ_NUM-1:0] req;
    logic               act;
    logic [REQ_NUM-1:0] ack;
    logic [2:0]         st;
  } vec_t;

  vec_t vt[14];

  initial begin
    // rst tm fo req  | act ack st
    vt[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 3'd0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 4'h0, 3'd1};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 4'h0, 3'd1};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 4'h0, 3'd2};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 4'h1, 3'd2};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 4'hB, 1'b1, 4'hB, 3'd2};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 4'hA, 1'b1, 4'hA, 3'd2};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 3'd3};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 4'h4, 3'd2};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 3'd2};
    vt[10] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 3'd0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 3'd0};
    vt[12] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 3'd1};
    vt[13] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 3'd0};

    // Reset with all requests asserted.
    rst = 1'b1; req = 4'hF;
    tick(); tick();
    check("rst_active", active, 0);
    check("rst_ack", ack, 0);
    check("rst_state", state, 0);
    rst = 1'b0;
    tick();
    check("rst_release_wake", state, 1);

    // Vector table.
    for (int i = 0; i < 14; i++) begin
      rst = vt[i].rst; testmode = vt[i].tm; force_on = vt[i].fo; req = vt[i].req;
      tick();
      check($sformatf("vec%0d_active", i), active, vt[i].act);
      check($sformatf("vec%0d_ack", i), ack, vt[i].ack);
      check($sformatf("vec%0d_state", i), state, vt[i].st);
    end

    // Wake latency and full gating sequence.
    rst = 1'b1; req = '0; testmode = 1'b0; force_on = 1'b0;
    tick(); rst = 1'b0; tick();
    req = 4'b0001;                               // edge t
    tick(); check("lat_active_t1", active, 1);
    tick(); tick(); check("lat_on_t3", state, 2);
    tick(); check("lat_ack_t4", ack, 4'b0001);
    repeat (6) tick();
    req = '0;                                    // drop at t+10
    tick();
    check("drop_ack_t11", ack, 0);
    check("drop_hold_t11", state, 3);
    repeat (15) tick(); check("hold_active_t26", active, 1);
    tick();
    check("gate_active_t27", active, 0);
    check("gate_cool_t27", state, 4);
    repeat (4) tick(); check("off_t31", state, 0);

    // Hysteresis: re-request during HOLD keeps the enable up.
    req = 4'b0010;
    repeat (3) tick(); check("hys_on", state, 2);
    tick(); check("hys_ack", ack, 4'b0010);
    req = '0;
    tick(); check("hys_hold", state, 3);
    for (int i = 0; i < 10; i++) begin
      tick(); check($sformatf("hys_active_%0d", i), active, 1);
    end
    req = 4'b0010;
    tick();
    check("hys_ack_back", ack, 4'b0010);
    check("hys_on_back", state, 2);

    // Minimum off time: request arrives one cycle into COOL.
    req = '0;
    tick();                                      // HOLD entry
    repeat (16) tick();                          // COOL entry (c)
    check("moff_cool", state, 4);
    check("moff_active_c", active, 0);
    tick();                                      // c+1
    req = 4'b0001;
    check("moff_active_c1", active, 0);
    for (int i = 2; i <= 4; i++) begin
      tick(); check($sformatf("moff_active_c%0d", i), active, 0);
    end
    check("moff_off_c4", state, 0);
    tick();
    check("moff_wake_c5", state, 1);
    check("moff_active_c5", active, 1);
    tick(); tick(); check("moff_on_c7", state, 2);
    check("moff_noack_c7", ack, 0);
    tick(); check("moff_ack_c8", ack, 4'b0001);

    // force_on with no requests.
    rst = 1'b1; req = '0; tick();
    rst = 1'b0; force_on = 1'b1;
    tick(); check("force_wake_active", active, 1);
    for (int i = 0; i < 100; i++) begin
      tick();
      check($sformatf("force_active_%0d", i), active, 1);
      check($sformatf("force_ack_%0d", i), ack, 0);
    end
    check("force_state_on", state, 2);
    force_on = 1'b0;

    // testmode in OFF asserts the enable without a clock edge.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    check("tm_pre_active", active, 0);
    testmode = 1'b1; #1;
    check("tm_active_same_cycle", active, 1);
    check("tm_state_off", state, 0);
    testmode = 1'b0;

    // Randomized stimulus against the reference model.
    rst = 1'b1; tick(); rst = 1'b0;
    begin
      int burst_left = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        if (burst_left == 0) begin
          burst_left = $urandom_range(1, 40);
          req        = ($urandom_range(0, 1) == 1) ? REQ_NUM'($urandom) : '0;
          force_on   = ($urandom_range(0, 19) == 0);
          testmode   = ($urandom_range(0, 29) == 0);
        end
        burst_left--;
        rst = ($urandom_range(0, 149) == 0);
        tick();
        check("rnd_state", state, m_state());
        check("rnd_active", active, ((m_wake_left > 0) || m_running || testmode) ? 1 : 0);
        check("rnd_ack", ack, m_ack);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
